matrix_scroll_ctrl: RTL and testbench

//  Scan/scroll controller for the 8x8 LED matrix. Owns a DEPTH-entry row pattern buffer with a write port.

---
 rtl/matrix_scroll_ctrl.sv | 95 +++++++++
 tb/tb_matrix_scroll_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/matrix_scroll_ctrl.sv
// matrix_scroll_ctrl: 8x8 LED matrix row scanner with a scrolling pattern buffer.
// Define MATRIX_BLANKING_EN to blank each row for BLANK_CYC cycles before it is driven.
module matrix_scroll_ctrl #(
  parameter int DEPTH = 16,
  parameter int SCAN_DIV = 8192,
  parameter int STEP_FRAMES = 381,
  parameter int BLANK_CYC = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          en_i,
  input  logic          dir_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  output logic [7:0]    segout_o,
  output logic [2:0]    scanout_o,
  output logic [AW-1:0] offset_o,
  output logic          frame_tick_o
);
  localparam int DMAX = SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC;
  localparam int DW = $clog2(DMAX + 1);
  localparam int FW = $clog2(STEP_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
  state_t state_q, state_d, row_start;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0] scan_q, scan_d;
  logic [AW-1:0] off_q, off_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] mem_q [DEPTH];
  logic scan_end, frame_end, step;
`ifdef MATRIX_BLANKING_EN
  assign row_start = BLANK;
`else
  assign row_start = SCAN;
`endif
  assign scan_end = state_q == SCAN && dwell_q == DW'(SCAN_DIV - 1);
  assign frame_end = scan_end && scan_q == 3'd7;
  assign step = fcnt_q == FW'(STEP_FRAMES - 1);
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q + 1'b1;
    scan_d = scan_q;
    off_d = off_q;
    fcnt_d = fcnt_q;
    if (state_q == IDLE) begin
      dwell_d = '0;
      scan_d = '0;
      state_d = en_i ? row_start : IDLE;
    end
`ifdef MATRIX_BLANKING_EN
    else if (state_q == BLANK && dwell_q == DW'(BLANK_CYC - 1)) begin
      state_d = SCAN;
      dwell_d = '0;
    end
`endif
    else if (scan_end) begin
      dwell_d = '0;
      scan_d = scan_q + 3'd1;
      state_d = row_start;
      if (frame_end) begin
        fcnt_d = step ? '0 : fcnt_q + 1'b1;
        off_d = step ? (dir_i ? off_q - 1'b1 : off_q + 1'b1) : off_q;
        state_d = en_i ? row_start : IDLE;
      end
    end
    // look up with next-cycle row/offset so segout lines up with scanout
    seg_d = state_d == SCAN ? mem_q[off_d + AW'(scan_d)] : 8'hFF;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      dwell_q <= '0;
      scan_q <= '0;
      off_q <= '0;
      fcnt_q <= '0;
      seg_q <= 8'hFF;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'hFF;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      scan_q <= scan_d;
      off_q <= off_d;
      fcnt_q <= fcnt_d;
      seg_q <= seg_d;
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end
  end
  assign segout_o = seg_q;
  assign scanout_o = scan_q;
  assign offset_o = off_q;
  assign frame_tick_o = frame_end;
endmodule

// File: tb/tb_matrix_scroll_ctrl.sv
// tb_matrix_scroll_ctrl: idle/write vector table plus scoreboard-checked scan, scroll, stop and write sequences.
module tb_matrix_scroll_ctrl;
  localparam int SD = 4, SF = 2, BC = 2;
`ifdef MATRIX_BLANKING_EN
  localparam int BL = BC;
`else
  localparam int BL = 0;
`endif
  localparam int RL = SD + BL, FL = 8 * RL;
  logic clk = 1'b0, reset_i, en_i, dir_i, wr_en_i, frame_tick_o;
  logic [3:0] wr_addr_i, offset_o;
  logic [7:0] wr_data_i, segout_o;
  logic [2:0] scanout_o;
  typedef struct {
    string tag;
    logic [7:0] seg;
    logic [2:0] scan;
    logic [3:0] off;
    logic tick;
  } exp_t;
  typedef struct {
    string tag;
    logic we;
    logic [3:0] wa;
    logic [7:0] wd;
    exp_t e;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[36];
  int n_vec = 0, n_bad = 0;
  int pos = -1, fdone = 0;
  logic [3:0] off_e = '0;
  logic [7:0] mdl [16];

  matrix_scroll_ctrl #(.DEPTH(16), .SCAN_DIV(SD), .STEP_FRAMES(SF), .BLANK_CYC(BC)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .dir_i(dir_i), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .segout_o(segout_o), .scanout_o(scanout_o),
    .offset_o(offset_o), .frame_tick_o(frame_tick_o));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({segout_o, scanout_o, offset_o, frame_tick_o} !== {e.seg, e.scan, e.off, e.tick}) begin
        n_bad++;
        $display("FAIL %s @%0t: got seg=%h scan=%0d off=%0d tick=%b, want seg=%h scan=%0d off=%0d tick=%b",
                 e.tag, $time, segout_o, scanout_o, offset_o, frame_tick_o, e.seg, e.scan, e.off, e.tick);
      end
    end
  end

  function automatic exp_t idle_exp(string t, logic [3:0] off);
    idle_exp.tag = t;
    idle_exp.seg = 8'hFF;
    idle_exp.scan = 3'd0;
    idle_exp.off = off;
    idle_exp.tick = 1'b0;
  endfunction

  task automatic do_reset(input logic we, input logic [3:0] wa, input logic [7:0] wd);
    reset_i = 1'b1; en_i = 1'b0; dir_i = 1'b0; wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    for (int i = 0; i < 16; i++) mdl[i] = 8'hFF;
    pos = -1; fdone = 0; off_e = '0;
    sb.push_back(idle_exp("reset", 4'd0));
    @(negedge clk);
  endtask

  // expected display state after the coming edge, from frame position and completed-frame count
  task automatic step(input string tag, input logic e, input logic d, input logic we = 1'b0,
                      input logic [3:0] wa = 4'd0, input logic [7:0] wd = 8'd0);
    int np, row;
    logic [3:0] noff;
    exp_t x;
    reset_i = 1'b0; en_i = e; dir_i = d; wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    noff = off_e;
    if (pos < 0) np = e ? 0 : -1;
    else if (pos == FL - 1) begin
      if (fdone % SF == SF - 1) noff = d ? off_e - 4'd1 : off_e + 4'd1;
      fdone++;
      np = e ? 0 : -1;
    end else np = pos + 1;
    row = np < 0 ? 0 : np / RL;
    x.tag = tag;
    x.scan = 3'(row);
    x.off = noff;
    x.tick = np == FL - 1;
    x.seg = (np < 0 || np % RL < BL) ? 8'hFF : mdl[4'(noff + 4'(row))];
    if (we) mdl[wa] = wd;
    pos = np;
    off_e = noff;
    sb.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 20; i++) tbl[i] = '{"idle", 1'b0, 4'd0, 8'd0, idle_exp("idle", 4'd0)};
    for (int a = 0; a < 16; a++) tbl[20 + a] = '{"wr_idle", 1'b1, 4'(a), {4'hA, 4'(a)}, idle_exp("wr_idle", 4'd0)};
    do_reset(1'b0, 4'd0, 8'd0);
    foreach (tbl[i]) begin
      reset_i = 1'b0; en_i = 1'b0; dir_i = 1'b0;
      wr_en_i = tbl[i].we; wr_addr_i = tbl[i].wa; wr_data_i = tbl[i].wd;
      if (tbl[i].we) mdl[tbl[i].wa] = tbl[i].wd;
      sb.push_back(tbl[i].e);
      @(negedge clk);
    end
    for (int i = 0; i < 3 * FL + 6; i++) step("run_up", 1'b1, 1'b0);
    for (int i = 0; i < FL && pos != 3 * RL; i++) step("to_row3", 1'b1, 1'b0);
    for (int i = 0; i < FL + 4; i++) step("stop", 1'b0, 1'b0);
    for (int i = 0; i < FL + 3; i++) step("resume", 1'b1, 1'b0);
    for (int i = 0; i < FL; i++) step("en_glitch", !(i >= RL && i < 4 * RL), 1'b0);
    for (int i = 0; i < FL && pos != 2 * RL + BL; i++) step("to_row2", 1'b1, 1'b0);
    step("wr_row2", 1'b1, 1'b0, 1'b1, off_e + 4'd2, 8'h00);
    for (int i = 0; i < RL + 2; i++) step("after_wr", 1'b1, 1'b0);
    for (int i = 0; i < 4 * FL; i++)
      step("rand", 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    do_reset(1'b1, 4'd0, 8'h00);
    for (int i = 0; i < FL + 2; i++) step("post_reset", 1'b1, 1'b0);
    do_reset(1'b0, 4'd0, 8'd0);
    for (int a = 0; a < 16; a++) step("refill", 1'b0, 1'b1, 1'b1, 4'(a), {4'hA, 4'(a)});
    for (int i = 0; i < 2 * FL + 2 * RL; i++) step("run_down", 1'b1, 1'b1);
    for (int i = 0; i < FL + 2; i++) step("stop_end", 1'b0, 1'b1);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
